// File: rtl/wb2apb_bridge_pkg.sv
// Shared types and constants for the Wishbone-to-APB bridge.
// Provides the FSM state enum, bus widths, the full byte-select mask and word alignment.
package apb_bridge_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS,
        ST_LAG,
        ST_RESP
    } bridge_state_e;

    localparam int APB_AW = 32;
    localparam int APB_DW = 32;

    localparam logic [3:0] FULL_SEL = 4'hF;

    function automatic logic [APB_AW-1:0] word_addr(
        input logic [APB_AW-1:0] a
    );
        return {a[APB_AW-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/wb2apb_bridge_if.sv
// Bundle of the Wishbone slave side and the APB master side of the bridge.
// The slave modport is the bridge's view; the master modport is the system or bench side.
interface wb2apb_if
    import apb_bridge_pkg::*;
();
    logic              wb_cyc;
    logic              wb_stb;
    logic              wb_we;
    logic [APB_AW-1:0] wb_adr;
    logic [APB_DW-1:0] wb_dat_i;
    logic [3:0]        wb_sel;
    logic [APB_DW-1:0] wb_dat_o;
    logic              wb_ack;
    logic              wb_err;

    logic [APB_AW-1:0] paddr;
    logic [APB_DW-1:0] pwdata;
    logic              pwrite;
    logic              psel;
    logic              penable;
    logic [APB_DW-1:0] prdata;
    logic              pready;
    logic              pslverr;

    modport slave (
        input  wb_cyc, wb_stb, wb_we, wb_adr, wb_dat_i, wb_sel,
        output wb_dat_o, wb_ack, wb_err,
        output paddr, pwdata, pwrite, psel, penable,
        input  prdata, pready, pslverr
    );

    modport master (
        output wb_cyc, wb_stb, wb_we, wb_adr, wb_dat_i, wb_sel,
        input  wb_dat_o, wb_ack, wb_err,
        input  paddr, pwdata, pwrite, psel, penable,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/wb2apb_bridge_timeout_ctr.sv
// Saturating ACCESS-cycle counter used to bound stalled APB slaves.
// Ports: i_clk, i_rst_n, i_clr (zero count), i_en (count), o_expired (last allowed cycle).
module bridge_timeout_ctr #(
    parameter int LIMIT = 16
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);
    localparam int CW = (LIMIT > 0) ? $clog2(LIMIT + 1) : 1;
    localparam logic [CW-1:0] LIM  = CW'(LIMIT);
    localparam logic [CW-1:0] LAST = CW'((LIMIT > 0) ? LIMIT - 1 : 0);

    logic [CW-1:0] r_count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en && (r_count != LIM)) begin
            r_count <= r_count + 1'b1;
        end
    end

    // Count holds the number of ACCESS cycles already completed, so the
    // flag marks the cycle that is the LIMIT-th one.
    assign o_expired = (LIMIT > 0) && (r_count >= LAST);
endmodule

// File: rtl/wb2apb_bridge.sv
// Wishbone B4 classic slave to APB3 master bridge, one outstanding transfer.
// Ports: clk, rst_n (async active-low), bus (wb2apb_if.slave: Wishbone slave + APB master).
module wb2apb_bridge
    import apb_bridge_pkg::*;
#(
    parameter int RDATA_LAG = 1,
    parameter int TIMEOUT   = 16
) (
    input logic     clk,
    input logic     rst_n,
    wb2apb_if.slave bus
);
    localparam bit LAG0 = (RDATA_LAG == 0);

    bridge_state_e     r_state;
    logic [APB_AW-1:0] r_paddr;
    logic [APB_DW-1:0] r_pwdata;
    logic              r_pwrite;
    logic              r_psel;
    logic              r_penable;
    logic [APB_DW-1:0] r_dat;
    logic              r_ack;
    logic              r_err;
    logic              r_slverr;

    logic w_req;
    logic w_bad_sel;
    logic w_start;
    logic w_expired;

    assign w_req     = bus.wb_cyc && bus.wb_stb;
    assign w_bad_sel = bus.wb_we && (bus.wb_sel != FULL_SEL);
    assign w_start   = (r_state == ST_IDLE) && w_req && !w_bad_sel;

    bridge_timeout_ctr #(
        .LIMIT(TIMEOUT)
    ) u_tmo (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_clr    (w_start),
        .i_en     ((r_state == ST_ACCESS) && !bus.pready),
        .o_expired(w_expired)
    );

    // Termination pulses are decided on the edge entering RESP, so the
    // pulse is gated by wb_cyc as seen at that edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_paddr   <= '0;
            r_pwdata  <= '0;
            r_pwrite  <= 1'b0;
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
            r_dat     <= '0;
            r_ack     <= 1'b0;
            r_err     <= 1'b0;
            r_slverr  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_req) begin
                        r_paddr  <= word_addr(bus.wb_adr);
                        r_pwdata <= bus.wb_dat_i;
                        r_pwrite <= bus.wb_we;
                        if (w_bad_sel) begin
                            r_err   <= 1'b1;
                            r_state <= ST_RESP;
                        end else begin
                            r_psel  <= 1'b1;
                            r_state <= ST_SETUP;
                        end
                    end
                end
                ST_SETUP: begin
                    r_penable <= 1'b1;
                    r_state   <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    if (bus.pready) begin
                        r_slverr  <= bus.pslverr;
                        r_psel    <= 1'b0;
                        r_penable <= 1'b0;
                        if (r_pwrite || LAG0) begin
                            if (!r_pwrite && !bus.pslverr) begin
                                r_dat <= bus.prdata;
                            end
                            r_ack   <= bus.wb_cyc && !bus.pslverr;
                            r_err   <= bus.wb_cyc && bus.pslverr;
                            r_state <= ST_RESP;
                        end else begin
                            r_state <= ST_LAG;
                        end
                    end else if (w_expired) begin
                        r_psel    <= 1'b0;
                        r_penable <= 1'b0;
                        r_err     <= bus.wb_cyc;
                        r_state   <= ST_RESP;
                    end
                end
                ST_LAG: begin
                    if (!r_slverr) begin
                        r_dat <= bus.prdata;
                    end
                    r_ack   <= bus.wb_cyc && !r_slverr;
                    r_err   <= bus.wb_cyc && r_slverr;
                    r_state <= ST_RESP;
                end
                ST_RESP: begin
                    r_ack   <= 1'b0;
                    r_err   <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.paddr    = r_paddr;
    assign bus.pwdata   = r_pwdata;
    assign bus.pwrite   = r_pwrite;
    assign bus.psel     = r_psel;
    assign bus.penable  = r_penable;
    assign bus.wb_dat_o = r_dat;
    assign bus.wb_ack   = r_ack;
    assign bus.wb_err   = r_err;
endmodule

// File: tb/tb_wb2apb_bridge.sv
// Self-checking bench for wb2apb_bridge (RDATA_LAG=1, TIMEOUT=4).
// Table-driven transfers against an APB slave model, plus back-to-back, cyc-drop and reset sequences.
`timescale 1ns/1ps
module tb_wb2apb_bridge;
    localparam int LAG = 1;
    localparam int TO  = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    wb2apb_if bus ();

    wb2apb_bridge #(
        .RDATA_LAG(LAG),
        .TIMEOUT  (TO)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        int          waits;
        logic        serr;
        logic        exp_err;
        int          exp_cyc;
        int          exp_psel;
        logic [31:0] exp_dat;
    } vec_t;

    typedef struct {
        logic        err;
        int          cyc;
        logic [31:0] dat;
    } exp_t;

    exp_t sbq[$];
    logic [31:0] mem [logic [31:0]];
    vec_t vt [14];

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic req_idle();
        bus.wb_cyc   = 1'b0;
        bus.wb_stb   = 1'b0;
        bus.wb_we    = 1'b0;
        bus.wb_adr   = '0;
        bus.wb_dat_i = '0;
        bus.wb_sel   = '0;
    endtask

    task automatic run_xfer(input vec_t v, input int idx);
        int          acc;
        int          ps;
        int          pe;
        bit          done;
        bit          hs;
        logic [31:0] pa;
        logic [31:0] lagd;
        exp_t        e;
        sbq.push_back('{v.exp_err, v.exp_cyc, v.exp_dat});
        pa = v.adr & 32'hFFFF_FFFC;
        acc = 0; ps = 0; pe = 0; done = 0; hs = 0; lagd = '0;
        bus.wb_cyc   = 1'b1;
        bus.wb_stb   = 1'b1;
        bus.wb_we    = v.we;
        bus.wb_adr   = v.adr;
        bus.wb_dat_i = v.dat;
        bus.wb_sel   = v.sel;
        for (int c = 1; c <= 40 && !done; c++) begin
            @(posedge clk);
            @(negedge clk);
            bus.prdata = 32'h0;
            if (hs) begin
                bus.prdata = lagd;
                hs = 0;
            end
            if (bus.psel) begin
                ps++;
                chk($sformatf("v%0d paddr", idx), bus.paddr, pa);
                chk($sformatf("v%0d pwrite", idx), 32'(bus.pwrite), 32'(v.we));
                if (v.we) chk($sformatf("v%0d pwdata", idx), bus.pwdata, v.dat);
            end
            if (bus.penable) pe++;
            if (bus.wb_ack || bus.wb_err) begin
                e = sbq.pop_front();
                chk($sformatf("v%0d err", idx), 32'(bus.wb_err), 32'(e.err));
                chk($sformatf("v%0d ack", idx), 32'(bus.wb_ack), 32'(!e.err));
                chk($sformatf("v%0d cycle", idx), 32'(c), 32'(e.cyc));
                chk($sformatf("v%0d dat_o", idx), bus.wb_dat_o, e.dat);
                done = 1;
                req_idle();
            end
            bus.pready  = 1'b0;
            bus.pslverr = 1'b0;
            if (bus.psel && bus.penable) begin
                acc++;
                if (acc > v.waits) begin
                    bus.pready  = 1'b1;
                    bus.pslverr = v.serr;
                    if (v.we && !v.serr) mem[pa] = v.dat;
                    lagd = mem.exists(pa) ? mem[pa] : 32'hBAD0_BAD0;
                    bus.prdata = (LAG != 0) ? ~lagd : lagd;
                    hs = 1;
                end
            end
        end
        if (!done) begin
            total++;
            bad++;
            $display("FAIL v%0d timeout: got no termination want one", idx);
            if (sbq.size() > 0) void'(sbq.pop_front());
            req_idle();
        end
        @(posedge clk);
        @(negedge clk);
        bus.pready = 1'b0;
        bus.prdata = 32'h0;
        chk($sformatf("v%0d extra pulse", idx), 32'(bus.wb_ack | bus.wb_err), 32'h0);
        chk($sformatf("v%0d psel cycles", idx), 32'(ps), 32'(v.exp_psel));
        chk($sformatf("v%0d penable cycles", idx), 32'(pe),
            32'((v.exp_psel > 0) ? v.exp_psel - 1 : 0));
    endtask

    initial begin
        int   first;
        int   second;
        int   acks;
        int   ps;
        vec_t vw;

        // we adr dat sel waits serr | err cyc psel dat_o
        vt[0]  = '{1'b1, 32'h40, 32'hDEAD_BEEF, 4'hF, 0,  1'b0, 1'b0, 3, 2, 32'h0};
        vt[1]  = '{1'b0, 32'h40, 32'h0,         4'hF, 0,  1'b0, 1'b0, 4, 2, 32'hDEAD_BEEF};
        vt[2]  = '{1'b1, 32'h44, 32'h1234_5678, 4'hF, 3,  1'b0, 1'b0, 6, 5, 32'hDEAD_BEEF};
        vt[3]  = '{1'b0, 32'h44, 32'h0,         4'hF, 3,  1'b0, 1'b0, 7, 5, 32'h1234_5678};
        vt[4]  = '{1'b1, 32'h48, 32'h0BAD_0BAD, 4'h3, 0,  1'b0, 1'b1, 1, 0, 32'h1234_5678};
        vt[5]  = '{1'b0, 32'h40, 32'h0,         4'hF, 99, 1'b0, 1'b1, 6, 5, 32'h1234_5678};
        vt[6]  = '{1'b0, 32'h40, 32'h0,         4'hF, 0,  1'b0, 1'b0, 4, 2, 32'hDEAD_BEEF};
        vt[7]  = '{1'b1, 32'h4C, 32'hCAFE_F00D, 4'hF, 1,  1'b1, 1'b1, 4, 3, 32'hDEAD_BEEF};
        vt[8]  = '{1'b0, 32'h44, 32'h0,         4'hF, 0,  1'b1, 1'b1, 4, 2, 32'hDEAD_BEEF};
        vt[9]  = '{1'b0, 32'h47, 32'h0,         4'h1, 0,  1'b0, 1'b0, 4, 2, 32'h1234_5678};
        vt[10] = '{1'b1, 32'h50, 32'h0000_55AA, 4'hF, 4,  1'b0, 1'b1, 6, 5, 32'h1234_5678};
        vt[11] = '{1'b1, 32'h0,  32'hFFFF_FFFF, 4'hF, 0,  1'b0, 1'b0, 3, 2, 32'h1234_5678};
        vt[12] = '{1'b0, 32'h0,  32'h0,         4'hF, 0,  1'b0, 1'b0, 4, 2, 32'hFFFF_FFFF};
        vt[13] = '{1'b1, 32'h40, 32'h0000_0001, 4'hE, 0,  1'b0, 1'b1, 1, 0, 32'hFFFF_FFFF};

        req_idle();
        bus.prdata  = '0;
        bus.pready  = 1'b0;
        bus.pslverr = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst psel", 32'(bus.psel), 32'h0);
        chk("rst penable", 32'(bus.penable), 32'h0);
        chk("rst ack", 32'(bus.wb_ack), 32'h0);
        chk("rst err", 32'(bus.wb_err), 32'h0);
        chk("rst dat_o", bus.wb_dat_o, 32'h0);
        chk("rst paddr", bus.paddr, 32'h0);
        chk("rst pwdata", bus.pwdata, 32'h0);
        chk("rst pwrite", 32'(bus.pwrite), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 14; i++) run_xfer(vt[i], i);

        // back-to-back writes with the request held across the ack
        bus.pready   = 1'b1;
        bus.wb_cyc   = 1'b1;
        bus.wb_stb   = 1'b1;
        bus.wb_we    = 1'b1;
        bus.wb_sel   = 4'hF;
        bus.wb_adr   = 32'h60;
        bus.wb_dat_i = 32'h1111_1111;
        first = -1;
        second = -1;
        for (int c = 1; c <= 20 && second < 0; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (c == 5) begin
                chk("b2b paddr", bus.paddr, 32'h64);
                chk("b2b pwdata", bus.pwdata, 32'h2222_2222);
            end
            if (bus.wb_ack) begin
                if (first < 0) begin
                    first = c;
                    bus.wb_adr   = 32'h64;
                    bus.wb_dat_i = 32'h2222_2222;
                end else begin
                    second = c;
                    req_idle();
                end
            end
        end
        req_idle();
        bus.pready = 1'b0;
        chk("b2b first ack", 32'(first), 32'd3);
        chk("b2b second ack", 32'(second), 32'd7);
        @(negedge clk);

        // wb_cyc dropped mid-transfer: APB completes, no pulse
        bus.pready   = 1'b1;
        bus.wb_cyc   = 1'b1;
        bus.wb_stb   = 1'b1;
        bus.wb_we    = 1'b1;
        bus.wb_sel   = 4'hF;
        bus.wb_adr   = 32'h70;
        bus.wb_dat_i = 32'h7777_7777;
        acks = 0;
        ps = 0;
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (c == 1) req_idle();
            if (bus.psel) ps++;
            if (bus.wb_ack || bus.wb_err) acks++;
        end
        bus.pready = 1'b0;
        chk("drop pulses", 32'(acks), 32'h0);
        chk("drop psel cycles", 32'(ps), 32'd2);

        // reset asserted during ACCESS
        bus.wb_cyc = 1'b1;
        bus.wb_stb = 1'b1;
        bus.wb_we  = 1'b0;
        bus.wb_sel = 4'hF;
        bus.wb_adr = 32'h40;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
        end
        chk("pre-rst penable", 32'(bus.penable), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("arst psel", 32'(bus.psel), 32'h0);
        chk("arst penable", 32'(bus.penable), 32'h0);
        chk("arst ack", 32'(bus.wb_ack), 32'h0);
        chk("arst err", 32'(bus.wb_err), 32'h0);
        chk("arst paddr", bus.paddr, 32'h0);
        req_idle();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        vw = '{1'b1, 32'h80, 32'hA5A5_5A5A, 4'hF, 0, 1'b0, 1'b0, 3, 2, 32'h0};
        run_xfer(vw, 99);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/wb2apb_bridge.md
# wb2apb_bridge

Wishbone B4 classic slave to APB3 master bridge, one outstanding transfer. It sits directly upstream of the SoC APB memory/peripheral fabric and drives `paddr/psel/penable/pwrite/pwdata` into that fabric. It converts each Wishbone cycle into exactly one APB transfer and returns `wb_ack`, or `wb_err`. It compensates for APB slaves that present `prdata` one cycle after the handshake, and bounds stalled slaves with a timeout.

## Interface
Parameters:
- `RDATA_LAG`, 1: cycles after APB handshake at which `prdata` is sampled (legal values 0 or 1).
- `TIMEOUT`, 16: maximum ACCESS cycles without `pready` before error; 0 disables the timeout.

Ports:
- `clk` in 1: single clock; all logic is posedge.
- `rst_n` in 1: reset; asynchronous, active-low.
- `wb_cyc`, `wb_stb`, `wb_we` in 1 each: Wishbone cycle, strobe, write enable.
- `wb_adr` in 32: byte address.
- `wb_dat_i` in 32: write data.
- `wb_sel` in 4: byte selects.
- `wb_dat_o` out 32: read data.
- `wb_ack`, `wb_err` out 1 each: one-cycle termination pulses.
- `paddr` out 32, `pwdata` out 32, `pwrite`, `psel`, `penable` out 1: APB master outputs.
- `prdata` in 32, `pready` in 1, `pslverr` in 1: APB slave response.

## Operation
- States: IDLE, SETUP, ACCESS, LAG, RESP.
- **IDLE**:
  - On `wb_cyc & wb_stb`, latch `wb_adr`, `wb_dat_i` and `wb_we`.
  - If `wb_we & (wb_sel != 4'hF)`, go to RESP with error and no APB access. Sub-word writes are unsupported.
  - Otherwise go to SETUP.
- **SETUP**: `psel=1`, `penable=0`, `paddr={adr[31:2],2'b00}`, `pwrite=we`, `pwdata=dat`. Go to ACCESS.
- **ACCESS**:
  - `psel=1`, `penable=1`; count cycles.
  - On `pready`:
    - Record `pslverr`.
    - For a write, or a read with `RDATA_LAG=0`, capture `prdata` (reads only) and go to RESP.
    - For a read with `RDATA_LAG=1`, go to LAG.
  - If the count reaches `TIMEOUT` without `pready`, go to RESP with error.
- **LAG**: `psel=0`, `penable=0`. Capture `prdata` into `wb_dat_o`. Go to RESP.
- **RESP**:
  - Pulse `wb_ack` if there was no error, else `wb_err`. The pulse is gated by `wb_cyc`.
  - Go to IDLE.
- `wb_dat_o` holds the last successful read value. It is not updated on writes or on errored reads.
- `wb_cyc` dropping mid-transfer does not abort APB. The transfer completes and the RESP pulse is suppressed.
- APB outputs hold stable from SETUP through the end of ACCESS. `psel` and `penable` are 0 in IDLE, LAG and RESP.
- Timeout counter: width `$clog2(TIMEOUT+1)`, cleared on entry to SETUP. It saturates and never wraps.

## Timing
- Reset values: all outputs 0; state IDLE; counter 0.
- Request sampled in cycle 0. `psel` asserts in cycle 1 and `penable` in cycle 2.
- Write with zero-wait `pready`: `wb_ack` in cycle 3.
- Read with zero-wait `pready`: `wb_ack` and valid `wb_dat_o` in cycle 3 (`RDATA_LAG=0`) or cycle 4 (`RDATA_LAG=1`).
- Each wait cycle of `pready` adds one cycle.
- Back-to-back: a request still asserted in the cycle after RESP is accepted as a new transfer.
- Minimum period is 4 cycles (write) or 5 cycles (lagged read).
- Reset asserted mid-transfer: outputs go to 0 immediately and asynchronously. No ack or err is issued.
- Timeout with `TIMEOUT=16`: `psel` and `penable` drop after the 16th ACCESS cycle, and `wb_err` pulses on the next cycle.
- A `pready` arriving after timeout is ignored.

## Structure
- Package `apb_bridge_pkg`:
  - state enum `bridge_state_e`;
  - `APB_AW=32`, `APB_DW=32`;
  - `FULL_SEL=4'hF`.
- One sub-module: `bridge_timeout_ctr` (load/clear, enable, saturate, `expired` flag). Everything else is in `wb2apb_bridge`.

## Test plan
- Write 0x0000_0040 with 0xDEAD_BEEF and `pready` tied to 1 → one APB transfer with `paddr=0x40`, `pwdata=0xDEADBEEF`, `pwrite=1`; `wb_ack` 3 cycles after the request; `psel` high for exactly 2 cycles.
- Read back 0x40 with `RDATA_LAG=1` and slave data appearing one cycle after the handshake → `wb_dat_o=0xDEADBEEF` concurrent with `wb_ack` in cycle 4.
- `pready` low for 3 cycles, then high → `penable` held for 4 cycles with `paddr` stable; ack delayed by 3 cycles.
- `TIMEOUT=4` and `pready` never asserted → `wb_err` after 4 ACCESS cycles; `wb_ack` never asserted; bridge returns to IDLE and the next transfer succeeds.
- Write with `wb_sel=4'h3` → `wb_err` in cycle 1; `psel` never asserted.
- `rst_n` dropped during ACCESS → `psel`, `penable`, `wb_ack` and `wb_err` are 0 in the same cycle. After release, the bridge is idle and a new write completes normally.
